// File: rtl/gbe_tx_packetizer_if.sv
// rtl/gbe_tx_packetizer_if.sv - transmit-side bus between the packetizer and the 10GbE core
interface gbe_tx_packetizer_if;
  logic        tx_valid;
  logic        tx_end_of_frame;
  logic [63:0] tx_data;
  logic [31:0] tx_dest_ip;
  logic [15:0] tx_dest_port;
  logic        tx_afull;
  logic        tx_overflow;

  modport master (
    output tx_valid,
    output tx_end_of_frame,
    output tx_data,
    output tx_dest_ip,
    output tx_dest_port,
    input  tx_afull,
    input  tx_overflow
  );

  modport slave (
    input  tx_valid,
    input  tx_end_of_frame,
    input  tx_data,
    input  tx_dest_ip,
    input  tx_dest_port,
    output tx_afull,
    output tx_overflow
  );
endinterface

// File: rtl/gbe_tx_packetizer.sv
// rtl/gbe_tx_packetizer.sv - FWFT-buffered fixed-length frame packetizer for the 10GbE tx port
// Optional statistics counters are built only when GBE_TX_STATS_EN is defined.
module gbe_tx_packetizer #(
  parameter int PAYLOAD_WORDS = 128,
  parameter int FIFO_AWIDTH   = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                in_valid,
  input  logic [63:0]         in_data,
  input  logic                in_sync,
  input  logic [31:0]         dest_ip,
  input  logic [15:0]         dest_port,
  gbe_tx_packetizer_if.master tx,
  output logic [31:0]         pkt_count,
  output logic [31:0]         drop_count,
  output logic [15:0]         tx_ovf_count
);

  localparam int LW = FIFO_AWIDTH + 1;
  localparam logic [LW-1:0] DEPTH     = LW'(2 ** FIFO_AWIDTH);
  localparam logic [LW-1:0] FRAME_LVL = LW'(PAYLOAD_WORDS);
  localparam logic [LW-1:0] LAST_IDX  = LW'(PAYLOAD_WORDS - 1);
  localparam logic [15:0]   HDR_LEN   = 16'(PAYLOAD_WORDS);

  typedef enum logic [0:0] {
    IDLE,
    PAYLOAD
  } state_t;

  state_t                 state;
  logic [63:0]            mem [2 ** FIFO_AWIDTH];
  logic [FIFO_AWIDTH-1:0] wr_ptr;
  logic [FIFO_AWIDTH-1:0] rd_ptr;
  logic [LW-1:0]          level;
  logic [LW-1:0]          word_cnt;
  logic [47:0]            frame_seq;

  logic        fifo_full;
  logic        wr_en;
  logic        rd_en;
  logic        hdr_load;
  logic        last_word;
  logic [47:0] hdr_seq;
  logic [63:0] rd_data;

  assign fifo_full = (level == DEPTH);
  assign wr_en     = in_valid && !fifo_full;
  assign hdr_load  = (state == IDLE) && en && (level >= FRAME_LVL) && !tx.tx_afull;
  assign rd_en     = (state == PAYLOAD) && !tx.tx_afull;
  assign last_word = (word_cnt == LAST_IDX);
  assign rd_data   = mem[rd_ptr];
  // A sync coinciding with a header load forces that header to carry 0.
  assign hdr_seq   = in_sync ? 48'd0 : frame_seq;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      level <= level + {{(LW-1){1'b0}}, wr_en} - {{(LW-1){1'b0}}, rd_en};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_seq <= '0;
    end else if (hdr_load) begin
      frame_seq <= hdr_seq + 48'd1;
    end else if (in_sync) begin
      frame_seq <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      word_cnt           <= '0;
      tx.tx_valid        <= 1'b0;
      tx.tx_end_of_frame <= 1'b0;
      tx.tx_data         <= '0;
      tx.tx_dest_ip      <= '0;
      tx.tx_dest_port    <= '0;
    end else begin
      tx.tx_valid        <= 1'b0;
      tx.tx_end_of_frame <= 1'b0;
      case (state)
        IDLE: begin
          if (hdr_load) begin
            tx.tx_valid     <= 1'b1;
            tx.tx_data      <= {hdr_seq, HDR_LEN};
            tx.tx_dest_ip   <= dest_ip;
            tx.tx_dest_port <= dest_port;
            word_cnt        <= '0;
            state           <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          // The whole frame is already buffered, so only afull can stall here.
          if (rd_en) begin
            tx.tx_valid <= 1'b1;
            tx.tx_data  <= rd_data;
            word_cnt    <= word_cnt + 1'b1;
            if (last_word) begin
              tx.tx_end_of_frame <= 1'b1;
              state              <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GBE_TX_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count    <= '0;
      drop_count   <= '0;
      tx_ovf_count <= '0;
    end else begin
      if (rd_en && last_word) begin
        pkt_count <= pkt_count + 32'd1;
      end
      if (in_valid && fifo_full && (drop_count != '1)) begin
        drop_count <= drop_count + 32'd1;
      end
      if (tx.tx_overflow && (tx_ovf_count != '1)) begin
        tx_ovf_count <= tx_ovf_count + 16'd1;
      end
    end
  end
`else
  logic unused_tx_overflow;
  assign unused_tx_overflow = tx.tx_overflow;
  assign pkt_count          = '0;
  assign drop_count         = '0;
  assign tx_ovf_count       = '0;
`endif

endmodule
